// File: rtl/scsi_xfer_sequencer.sv
// scsi_xfer_sequencer: sequences the SCSI byte-wide datapath between FIFO, CPU and SCSI chip.
// DMA bytes run under DREQ/DACK; CPU register accesses are slotted between DMA bytes.
// Optional macro SCSI_FLUSH_EN adds FLUSH/FLUSH_BYTES to commit a partial S2F longword.
module scsi_xfer_sequencer #(
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned SETUP_CYC  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DMAENA,
  input  logic       DMADIR,
  input  logic       DREQ,
  output logic       DACK,
  input  logic       FIFO_EMPTY,
  input  logic       FIFO_FULL,
  output logic       FIFO_RD,
  output logic       FIFO_BYTE_WE,
  output logic       FIFO_COMMIT,
  input  logic       CPU_REQ,
  input  logic       CPU_RW,
  output logic       CPU_ACK,
  output logic       F2S,
  output logic       S2F,
  output logic       CPU2S,
  output logic       S2CPU,
  output logic       BO0,
  output logic       BO1,
  output logic       LS2CPU,
  output logic       SCSI_RD,
  output logic       SCSI_WR,
`ifdef SCSI_FLUSH_EN
  input  logic       FLUSH,
  output logic [1:0] FLUSH_BYTES,
`endif
  output logic       BUSY
);

  localparam int unsigned TW = 3;
  localparam logic [TW-1:0] SETUP_LD  = (SETUP_CYC  > 1) ? TW'(SETUP_CYC - 1)  : '0;
  localparam logic [TW-1:0] STROBE_LD = (STROBE_CYC > 1) ? TW'(STROBE_CYC - 1) : '0;
  localparam bit HAS_SETUP = (SETUP_CYC != 0);

  typedef enum logic [3:0] {
    IDLE, F_FETCH, SETUP, STROBE, HOLD, S_STORE, C_SETUP, C_STROBE, C_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic          rw_q, rw_d;
  logic          go_byte;
  logic          flush_d;

  logic dack_q, dack_d, fifo_rd_q, fifo_rd_d, we_q, we_d, commit_q, commit_d;
  logic ack_q, ack_d, f2s_q, f2s_d, s2f_q, s2f_d, cpu2s_q, cpu2s_d, s2cpu_q, s2cpu_d;
  logic [1:0] bo_q, bo_d, fbytes_q, fbytes_d;
  logic ls2cpu_q, ls2cpu_d, rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;

  // Next-state: IDLE arbitration (CPU first, then DMA) and timed byte/access phases
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    rw_d    = rw_q;
    go_byte = 1'b0;
    flush_d = 1'b0;
    case (state_q)
      IDLE: begin
        dir_d = DMADIR;
        if (CPU_REQ) begin
          rw_d = CPU_RW;
          if (HAS_SETUP) begin
            state_d = C_SETUP;
            timer_d = SETUP_LD;
          end else begin
            state_d = C_STROBE;
            timer_d = STROBE_LD;
          end
        end else if ((DMADIR != dir_q) && (lane_q != 2'd0)) begin
          // direction flip discards the partial longword
          lane_d = 2'd0;
        end
`ifdef SCSI_FLUSH_EN
        else if (FLUSH && !DMADIR && (lane_q != 2'd0)) begin
          lane_d  = 2'd0;
          flush_d = 1'b1;
        end
`endif
        else if (DMAENA && DREQ) begin
          if (DMADIR) begin
            if (lane_q != 2'd0) go_byte = 1'b1;
            else if (!FIFO_EMPTY) state_d = F_FETCH;
          end else if ((lane_q != 2'd0) || !FIFO_FULL) begin
            go_byte = 1'b1;
          end
        end
      end
      F_FETCH: go_byte = 1'b1;
      SETUP: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        else begin
          state_d = STROBE;
          timer_d = STROBE_LD;
        end
      end
      STROBE: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        else state_d = dir_q ? HOLD : S_STORE;
      end
      HOLD, S_STORE: begin
        lane_d  = lane_q + 2'd1;
        state_d = IDLE;
      end
      C_SETUP: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        else begin
          state_d = C_STROBE;
          timer_d = STROBE_LD;
        end
      end
      C_STROBE: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        else state_d = C_DONE;
      end
      C_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_byte) begin
      if (HAS_SETUP) begin
        state_d = SETUP;
        timer_d = SETUP_LD;
      end else begin
        state_d = STROBE;
        timer_d = STROBE_LD;
      end
    end
  end

  // Output decode from the next state so every output is registered alongside the state
  always_comb begin
    dack_d    = 1'b0;
    fifo_rd_d = 1'b0;
    we_d      = 1'b0;
    commit_d  = flush_d;
    fbytes_d  = flush_d ? lane_q : 2'd0;
    ack_d     = 1'b0;
    f2s_d     = 1'b0;
    s2f_d     = 1'b0;
    cpu2s_d   = 1'b0;
    s2cpu_d   = 1'b0;
    bo_d      = 2'd0;
    ls2cpu_d  = 1'b1;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    busy_d    = (state_d != IDLE);
    case (state_d)
      F_FETCH: begin
        fifo_rd_d = 1'b1;
        f2s_d     = 1'b1;
        bo_d      = lane_d;
      end
      SETUP, STROBE, HOLD: begin
        f2s_d  = dir_d;
        s2f_d  = !dir_d;
        dack_d = 1'b1;
        bo_d   = lane_d;
        if (state_d == STROBE) begin
          wr_d = dir_d;
          rd_d = !dir_d;
        end
      end
      S_STORE: begin
        s2f_d    = 1'b1;
        dack_d   = 1'b1;
        we_d     = 1'b1;
        bo_d     = lane_d;
        commit_d = (lane_d == 2'd3);
      end
      C_SETUP, C_STROBE, C_DONE: begin
        cpu2s_d = !rw_d;
        s2cpu_d = rw_d;
        if (state_d == C_STROBE) begin
          wr_d     = !rw_d;
          rd_d     = rw_d;
          ls2cpu_d = !(rw_d && (timer_d == '0));
        end
        ack_d = (state_d == C_DONE);
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;   lane_q <= 2'd0;   timer_q <= '0;
      dir_q <= 1'b0;     rw_q <= 1'b0;
      dack_q <= 1'b0;    fifo_rd_q <= 1'b0; we_q <= 1'b0;   commit_q <= 1'b0;
      fbytes_q <= 2'd0;  ack_q <= 1'b0;     f2s_q <= 1'b0;  s2f_q <= 1'b0;
      cpu2s_q <= 1'b0;   s2cpu_q <= 1'b0;   bo_q <= 2'd0;   ls2cpu_q <= 1'b1;
      rd_q <= 1'b0;      wr_q <= 1'b0;      busy_q <= 1'b0;
    end else begin
      state_q <= state_d; lane_q <= lane_d;   timer_q <= timer_d;
      dir_q <= dir_d;     rw_q <= rw_d;
      dack_q <= dack_d;   fifo_rd_q <= fifo_rd_d; we_q <= we_d; commit_q <= commit_d;
      fbytes_q <= fbytes_d; ack_q <= ack_d;   f2s_q <= f2s_d; s2f_q <= s2f_d;
      cpu2s_q <= cpu2s_d; s2cpu_q <= s2cpu_d; bo_q <= bo_d;   ls2cpu_q <= ls2cpu_d;
      rd_q <= rd_d;       wr_q <= wr_d;       busy_q <= busy_d;
    end
  end

  assign DACK         = dack_q;
  assign FIFO_RD      = fifo_rd_q;
  assign FIFO_BYTE_WE = we_q;
  assign FIFO_COMMIT  = commit_q;
  assign CPU_ACK      = ack_q;
  assign F2S          = f2s_q;
  assign S2F          = s2f_q;
  assign CPU2S        = cpu2s_q;
  assign S2CPU        = s2cpu_q;
  assign BO0          = bo_q[0];
  assign BO1          = bo_q[1];
  assign LS2CPU       = ls2cpu_q;
  assign SCSI_RD      = rd_q;
  assign SCSI_WR      = wr_q;
  assign BUSY         = busy_q;
`ifdef SCSI_FLUSH_EN
  assign FLUSH_BYTES  = fbytes_q;
`else
  logic unused_fbytes;
  assign unused_fbytes = ^fbytes_q;
`endif

endmodule

// File: tb/tb_scsi_xfer_sequencer.sv
// Bench for scsi_xfer_sequencer: one-cycle arbitration vectors plus DMA/CPU/reset sequences.
module tb_scsi_xfer_sequencer;

  localparam int unsigned STROBE_CYC = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1, DMAENA = 1'b0, DMADIR = 1'b0, DREQ = 1'b0;
  logic FIFO_EMPTY = 1'b1, FIFO_FULL = 1'b0, CPU_REQ = 1'b0, CPU_RW = 1'b0;
  logic DACK, FIFO_RD, FIFO_BYTE_WE, FIFO_COMMIT, CPU_ACK;
  logic F2S, S2F, CPU2S, S2CPU, BO0, BO1, LS2CPU, SCSI_RD, SCSI_WR, BUSY;
`ifdef SCSI_FLUSH_EN
  logic FLUSH = 1'b0;
  logic [1:0] FLUSH_BYTES;
`endif

  scsi_xfer_sequencer #(.STROBE_CYC(2), .SETUP_CYC(1)) dut (
    .CLK(CLK), .RST(RST), .DMAENA(DMAENA), .DMADIR(DMADIR), .DREQ(DREQ), .DACK(DACK),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FULL(FIFO_FULL), .FIFO_RD(FIFO_RD),
    .FIFO_BYTE_WE(FIFO_BYTE_WE), .FIFO_COMMIT(FIFO_COMMIT),
    .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_ACK(CPU_ACK),
    .F2S(F2S), .S2F(S2F), .CPU2S(CPU2S), .S2CPU(S2CPU), .BO0(BO0), .BO1(BO1),
    .LS2CPU(LS2CPU), .SCSI_RD(SCSI_RD), .SCSI_WR(SCSI_WR),
`ifdef SCSI_FLUSH_EN
    .FLUSH(FLUSH), .FLUSH_BYTES(FLUSH_BYTES),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // scoreboards: BO expected at each DMA strobe start, {BO,COMMIT} at each FIFO byte write
  logic [1:0] exp_bo_q[$];
  logic [2:0] exp_st_q[$];

  int strobe_cnt = 0, fifo_rd_cnt = 0, we_cnt = 0, commit_cnt = 0;
  int ack_cnt = 0, ls_low_cnt = 0, ack_at_strobe = 0;
  logic s2cpu_at_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/unexpected required=event", name);
  endtask

  function automatic logic [9:0] outv();
    return {BUSY, DACK, FIFO_RD, F2S, S2F, CPU2S, S2CPU, LS2CPU, SCSI_RD, SCSI_WR};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Output monitor, sampled 1 time unit after each rising edge
  logic prev_strb = 1'b0;
  int   run_len = 0;
  always begin
    logic dma_strb;
    logic [1:0] e_bo;
    logic [2:0] e_st;
    @(posedge CLK);
    #1;
    dma_strb = (SCSI_WR | SCSI_RD) & (F2S | S2F);
    if (RST) begin
      prev_strb = 1'b0;
      run_len   = 0;
    end else begin
      if (dma_strb && !prev_strb) begin
        strobe_cnt++;
        run_len = 1;
        if (exp_bo_q.size() == 0) note_fail("dma_strobe_unexpected");
        else begin
          e_bo = exp_bo_q.pop_front();
          check("dma_bo", 32'({BO1, BO0}), 32'(e_bo));
        end
        check("dma_dack", 32'(DACK), 32'd1);
      end else if (dma_strb) begin
        run_len++;
      end else if (prev_strb) begin
        check("strobe_len", 32'(run_len), 32'(STROBE_CYC));
      end
      prev_strb = dma_strb;
      if (FIFO_RD) fifo_rd_cnt++;
      if (FIFO_BYTE_WE) begin
        we_cnt++;
        if (exp_st_q.size() == 0) note_fail("byte_we_unexpected");
        else begin
          e_st = exp_st_q.pop_front();
          check("store_bo_commit", 32'({BO1, BO0, FIFO_COMMIT}), 32'(e_st));
        end
      end
      if (FIFO_COMMIT) commit_cnt++;
      if (CPU_ACK) begin
        ack_cnt++;
        ack_at_strobe = strobe_cnt;
        s2cpu_at_ack  = S2CPU;
      end
      if (!LS2CPU) ls_low_cnt++;
    end
  end

  typedef struct {
    string      name;
    logic       rst, ena, dir, dreq, empty, full, creq, crw;
    logic [9:0] exp;  // {BUSY,DACK,FIFO_RD,F2S,S2F,CPU2S,S2CPU,LS2CPU,SCSI_RD,SCSI_WR}
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, base_s, base_rd, base_we, base_c, base_ack, base_ls;

    vecs[0] = '{"reset_state",    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b0000000100};
    vecs[1] = '{"f2s_empty_idle", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'b0000000100};
    vecs[2] = '{"f2s_fetch",      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'b1011000100};
    vecs[3] = '{"s2f_setup",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'b1100100100};
    vecs[4] = '{"s2f_full_stall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'b0000000100};
    vecs[5] = '{"dma_disabled",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000000100};
    vecs[6] = '{"cpu_read_wins",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'b1000001100};
    vecs[7] = '{"cpu_write",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'b1000010100};
    vecs[8] = '{"no_dreq_idle",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000000100};

    // one-cycle arbitration vectors, each from a fresh reset
    for (int i = 0; i < 9; i++) begin
      RST = 1'b1; DMAENA = 1'b0; DREQ = 1'b0; CPU_REQ = 1'b0;
      tick();
      RST = vecs[i].rst; DMAENA = vecs[i].ena; DMADIR = vecs[i].dir; DREQ = vecs[i].dreq;
      FIFO_EMPTY = vecs[i].empty; FIFO_FULL = vecs[i].full;
      CPU_REQ = vecs[i].creq; CPU_RW = vecs[i].crw;
      tick();
      check(vecs[i].name, 32'(outv()), 32'(vecs[i].exp));
    end

    // F2S: one longword unpacked into 4 bytes, then FIFO empty keeps the sequencer idle
    RST = 1'b1; DREQ = 1'b0; CPU_REQ = 1'b0; tick();
    base_s = strobe_cnt; base_rd = fifo_rd_cnt;
    for (int b = 0; b < 4; b++) exp_bo_q.push_back(2'(b));
    RST = 1'b0; DMAENA = 1'b1; DMADIR = 1'b1; FIFO_EMPTY = 1'b0; DREQ = 1'b1;
    for (n = 0; n < 20 && !FIFO_RD; n++) tick();
    if (n == 20) note_fail("f2s_fetch_wait");
    FIFO_EMPTY = 1'b1;
    for (n = 0; n < 100 && !((strobe_cnt - base_s == 4) && !BUSY); n++) tick();
    if (n == 100) note_fail("f2s_4bytes_wait");
    repeat (4) tick();
    check("f2s_fifo_rd_once", 32'(fifo_rd_cnt - base_rd), 32'd1);
    check("f2s_empty_stays_idle", 32'({BUSY, DACK}), 32'd0);

    // S2F: 8 bytes, commit on the 4th and 8th only
    RST = 1'b1; DREQ = 1'b0; tick();
    base_we = we_cnt; base_c = commit_cnt;
    for (int b = 0; b < 8; b++) begin
      exp_bo_q.push_back(2'(b % 4));
      exp_st_q.push_back({2'(b % 4), (b % 4) == 3});
    end
    RST = 1'b0; DMADIR = 1'b0; FIFO_FULL = 1'b0; DREQ = 1'b1;
    for (n = 0; n < 200 && (we_cnt - base_we < 8); n++) tick();
    if (n == 200) note_fail("s2f_8bytes_wait");
    DREQ = 1'b0;
    tick();
    check("s2f_commit_count", 32'(commit_cnt - base_c), 32'd2);
    FIFO_FULL = 1'b1; DREQ = 1'b1;
    repeat (5) tick();
    check("s2f_full_stall", 32'({BUSY, DACK}), 32'd0);
    DREQ = 1'b0; FIFO_FULL = 1'b0;

    // CPU read slotted into F2S after the byte at lane 1, DMA resumes at lane 2
    RST = 1'b1; tick();
    base_s = strobe_cnt; base_rd = fifo_rd_cnt; base_ack = ack_cnt; base_ls = ls_low_cnt;
    for (int b = 0; b < 4; b++) exp_bo_q.push_back(2'(b));
    RST = 1'b0; DMADIR = 1'b1; FIFO_EMPTY = 1'b0; DREQ = 1'b1;
    for (n = 0; n < 20 && !FIFO_RD; n++) tick();
    if (n == 20) note_fail("cpu_fetch_wait");
    FIFO_EMPTY = 1'b1;
    for (n = 0; n < 50 && (strobe_cnt - base_s < 2); n++) tick();
    if (n == 50) note_fail("cpu_lane1_wait");
    CPU_REQ = 1'b1; CPU_RW = 1'b1;
    for (n = 0; n < 30 && !CPU_ACK; n++) tick();
    if (n == 30) note_fail("cpu_ack_wait");
    CPU_REQ = 1'b0;
    tick();
    check("cpu_s2cpu_idle", 32'(S2CPU), 32'd0);
    for (n = 0; n < 100 && !((strobe_cnt - base_s == 4) && !BUSY); n++) tick();
    if (n == 100) note_fail("cpu_resume_wait");
    check("cpu_ack_count", 32'(ack_cnt - base_ack), 32'd1);
    check("cpu_slot_after_lane1", 32'(ack_at_strobe - base_s), 32'd2);
    check("cpu_s2cpu_at_ack", 32'(s2cpu_at_ack), 32'd1);
    check("cpu_ls2cpu_low_clocks", 32'(ls_low_cnt - base_ls), 32'd1);
    check("cpu_no_extra_fifo_rd", 32'(fifo_rd_cnt - base_rd), 32'd1);

    // Reset during the strobe of the second S2F byte: partial longword abandoned
    RST = 1'b1; DREQ = 1'b0; tick();
    base_we = we_cnt; base_c = commit_cnt;
    exp_bo_q.push_back(2'd0); exp_bo_q.push_back(2'd1);
    exp_st_q.push_back(3'b000);
    RST = 1'b0; DMADIR = 1'b0; FIFO_FULL = 1'b0; DREQ = 1'b1;
    for (n = 0; n < 30 && (we_cnt - base_we < 1); n++) tick();
    if (n == 30) note_fail("rst_first_byte_wait");
    for (n = 0; n < 30 && !SCSI_RD; n++) tick();
    if (n == 30) note_fail("rst_strobe_wait");
    RST = 1'b1;
    tick();
    check("rst_mid_strobe_outputs", 32'(outv()), 32'(10'b0000000100));
    RST = 1'b0;
    exp_bo_q.push_back(2'd0);
    exp_st_q.push_back(3'b000);
    for (n = 0; n < 30 && (we_cnt - base_we < 2); n++) tick();
    if (n == 30) note_fail("rst_lane0_byte_wait");
    DREQ = 1'b0;
    tick();
    check("rst_no_commit", 32'(commit_cnt - base_c), 32'd0);

`ifdef SCSI_FLUSH_EN
    // Flush after 3 S2F bytes commits a 3-byte partial longword
    RST = 1'b1; tick();
    base_we = we_cnt;
    for (int b = 0; b < 3; b++) begin
      exp_bo_q.push_back(2'(b));
      exp_st_q.push_back({2'(b), 1'b0});
    end
    RST = 1'b0; DMADIR = 1'b0; DREQ = 1'b1;
    for (n = 0; n < 60 && (we_cnt - base_we < 3); n++) tick();
    if (n == 60) note_fail("flush_3bytes_wait");
    DREQ = 1'b0;
    repeat (2) tick();
    FLUSH = 1'b1;
    tick();
    check("flush_commit_bytes", 32'({FIFO_COMMIT, FLUSH_BYTES}), 32'(3'b111));
    FLUSH = 1'b0;
    tick();
    check("flush_bytes_cleared", 32'({FIFO_COMMIT, FLUSH_BYTES}), 32'd0);
    exp_bo_q.push_back(2'd0);
    exp_st_q.push_back(3'b000);
    DREQ = 1'b1;
    for (n = 0; n < 30 && (we_cnt - base_we < 4); n++) tick();
    if (n == 30) note_fail("flush_lane0_wait");
    DREQ = 1'b0;
    tick();
`endif

    repeat (3) tick();
    check("bo_scoreboard_drained", 32'(exp_bo_q.size()), 32'd0);
    check("store_scoreboard_drained", 32'(exp_st_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scsi_xfer_sequencer.md
Name: scsi_xfer_sequencer

Overview:
Sequences the SCSI byte-wide datapath. Generates the F2S/S2F/CPU2S/S2CPU/BO0/BO1/LS2CPU controls and the SCSI chip read/write strobes.
- DMA mode: unpacks FIFO longwords to SCSI bytes, or packs SCSI bytes into FIFO byte lanes, under the chip's DREQ/DACK handshake.
- CPU mode: arbitrates CPU register accesses to the SCSI chip between DMA byte cycles.

Parameters:
STROBE_CYC, 2, clocks SCSI_RD/SCSI_WR stay asserted (1..7)
SETUP_CYC, 1, clocks data/controls are stable before the strobe (0..3)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
DMAENA  in  1  DMA enable; deassertion stops at the next byte boundary
DMADIR  in  1  1 = FIFO->SCSI (F2S), 0 = SCSI->FIFO (S2F)
DREQ  in  1  SCSI chip data request
DACK  out  1  SCSI chip data acknowledge
FIFO_EMPTY  in  1  FIFO has no longword to read
FIFO_FULL  in  1  FIFO cannot accept a longword
FIFO_RD  out  1  one-clock pop of the FIFO head longword
FIFO_BYTE_WE  out  1  one-clock write of the SCSI byte into lane BO1:BO0
FIFO_COMMIT  out  1  one-clock commit of the packed longword
CPU_REQ  in  1  CPU requests a SCSI register access
CPU_RW  in  1  1 = read, 0 = write
CPU_ACK  out  1  one-clock completion pulse
F2S, S2F, CPU2S, S2CPU  out  1 each  datapath direction selects, mutually exclusive
BO0, BO1  out  1 each  byte-lane select
LS2CPU  out  1  active-low read-data latch enable
SCSI_RD, SCSI_WR  out  1 each  SCSI chip strobes
BUSY  out  1  sequencer not in IDLE

Behaviour:
- Reset (RST sampled high at a CLK rising edge):
  - State goes to IDLE; lane counter = 0; strobe timer = 0.
  - All outputs 0, except LS2CPU = 1.
  - Reset mid-transfer abandons any partial longword; no COMMIT is issued.
- States: IDLE, F_FETCH, SETUP, STROBE, HOLD, S_STORE, C_SETUP, C_STROBE, C_DONE.
- Arbitration in IDLE, priority order:
  1. CPU_REQ wins if no DMA byte is in flight; this gives the CPU a slot between DMA bytes.
  2. Otherwise DMA proceeds when DMAENA & DREQ and the FIFO condition holds.
- F2S path:
  - IDLE -> F_FETCH when lane = 0 and FIFO_EMPTY = 0. FIFO_RD pulses one clock, then SETUP.
  - If lane != 0, go directly to SETUP (longword already held).
  - SETUP lasts SETUP_CYC clocks with F2S = 1, BO1:BO0 = lane, DACK = 1.
  - STROBE lasts STROBE_CYC clocks with SCSI_WR = 1.
  - HOLD lasts 1 clock: strobe low, F2S and DACK still high. Lane increments (wraps 3 -> 0), then IDLE.
- S2F path:
  - IDLE -> SETUP when lane != 0, or FIFO_FULL = 0.
  - SETUP/STROBE as above with S2F = 1 and SCSI_RD = 1.
  - S_STORE: FIFO_BYTE_WE pulses one clock with BO = lane. If lane = 3, FIFO_COMMIT pulses in the same clock. Lane increments, then IDLE.
- CPU path:
  - C_SETUP: CPU2S = 1 if CPU_RW = 0, else S2CPU = 1. BO1:BO0 = 0. Lasts SETUP_CYC clocks.
  - C_STROBE: SCSI_WR or SCSI_RD for STROBE_CYC clocks. For reads, LS2CPU = 0 on the last strobe clock.
  - C_DONE: CPU_ACK pulses one clock, then IDLE. S2CPU drops to 0 in IDLE.
- Lane counter is preserved across CPU accesses and across DMAENA low.
- DMADIR change with lane != 0 resets lane to 0. No COMMIT is issued.
- DREQ dropping after SETUP has started is ignored; the byte completes.
- Exactly one of F2S/S2F/CPU2S/S2CPU is high at any time; all are 0 in IDLE.

Optional Feature:
SCSI_FLUSH_EN adds input FLUSH (1-bit) and output FLUSH_BYTES (2-bit).
- With the macro: FLUSH high in IDLE with S2F direction and lane != 0 does the following:
  - Pulses FIFO_COMMIT.
  - Drives FLUSH_BYTES = lane (count of valid bytes) for that clock, else 0.
  - Sets lane to 0.
  - FLUSH with lane = 0 is a no-op.
- Without the macro: no such ports exist. Partial longwords stay pending until completed or reset.

Test Plan:
- F2S, FIFO holds 0xAABBCCDD, DREQ held: FIFO_RD once; 4 byte cycles with BO = 0,1,2,3 in order; each with SCSI_WR high STROBE_CYC=2 clocks; DACK high throughout each byte.
- S2F, 8 bytes from chip: FIFO_BYTE_WE ×8, FIFO_COMMIT on the 4th and 8th only. FIFO_FULL=1 at lane 0 stalls with DACK=0.
- CPU read during F2S at lane 2: access inserted after HOLD. S2CPU=1, LS2CPU low 1 clock, CPU_ACK pulse. Next DMA byte resumes at BO=2 with no extra FIFO_RD.
- RST asserted during STROBE: next clock all strobes/selects 0, LS2CPU=1, lane=0, no COMMIT.
- FIFO_EMPTY=1 with DREQ=1 in F2S, lane 0: stays IDLE, DACK=0, BUSY=0.
- (SCSI_FLUSH_EN) S2F 3 bytes then FLUSH: FIFO_COMMIT pulse with FLUSH_BYTES=3, lane returns to 0.
